// File: rtl/regfile_pkg.sv
// Shared register-file widths, types and the x0 constant for the writeback path.
// Pure declarations, no timing or flow control.
package regfile_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_DATA_WIDTH = 32;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [REG_DATA_WIDTH-1:0] reg_data_t;

  localparam reg_addr_t REG_ZERO = '0;

  typedef struct packed {
    reg_addr_t rd;
    reg_data_t data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first request after ptr wins; grant is one-hot or zero.
// Purely combinational; no backpressure of its own.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_vld
);

  logic [IW-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = ptr;
    for (int i = 0; i < N; i++) begin
      // walk ptr+1, ptr+2, ... with wrap at N (N need not be a power of two)
      cand = (cand == IW'(N - 1)) ? '0 : cand + 1'b1;
      if (!grant_vld && req[cand]) begin
        grant_vld   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Round-robin share of the regfile write port plus a pending-write scoreboard for hazards.
// One cycle accept->wr_en; losing requesters simply see req_ready low and hold.
module regfile_wb_scheduler
  import regfile_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter int DATA_WIDTH = REG_DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_rd,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic                          wr_en,
  output logic [ADDR_WIDTH-1:0]         wr_rd,
  output logic [DATA_WIDTH-1:0]         wr_din,
  input  logic                          issue_valid,
  input  logic [ADDR_WIDTH-1:0]         issue_rd,
  output logic                          issue_ready,
  input  logic [ADDR_WIDTH-1:0]         rs1,
  input  logic [ADDR_WIDTH-1:0]         rs2,
  output logic                          rs1_busy,
  output logic                          rs2_busy,
  output logic                          idle
);

  localparam int IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NREG = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(REG_ZERO);

  logic [IW-1:0]         ptr;
  logic [NUM_REQ-1:0]    grant;
  logic [IW-1:0]         grant_idx;
  logic                  grant_vld;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [NREG-1:0]       busy;
  logic [NREG-1:0]       busy_nxt;
  logic                  issue_set;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign req_ready = rst ? '0 : grant;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_rd   = req_rd[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // x0 writes are consumed here so the regfile never sees them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr    <= IW'(NUM_REQ - 1);
      wr_en  <= 1'b0;
      wr_rd  <= '0;
      wr_din <= '0;
    end else begin
      wr_en <= 1'b0;
      if (grant_vld) begin
        ptr    <= grant_idx;
        wr_en  <= (sel_rd != ZERO);
        wr_rd  <= sel_rd;
        wr_din <= sel_data;
      end
    end
  end

  assign issue_ready = ~busy[issue_rd] | (issue_rd == ZERO);
  assign issue_set   = issue_valid & issue_ready & (issue_rd != ZERO);

  // a new reservation landing with the commit of the same register must survive
  always_comb begin
    busy_nxt = busy;
    if (wr_en) busy_nxt[wr_rd] = 1'b0;
    if (issue_set) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  assign rs1_busy = busy[rs1] & (rs1 != ZERO);
  assign rs2_busy = busy[rs2] & (rs2 != ZERO);
  assign idle     = ~(|busy) & ~wr_en;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed hazard/arbitration cases plus a random writeback scoreboard.
module tb_regfile_wb_scheduler;
  import regfile_pkg::*;

  localparam int NR = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*AW-1:0] req_rd;
  logic [NR*DW-1:0] req_data;
  logic             wr_en;
  logic [AW-1:0]    wr_rd;
  logic [DW-1:0]    wr_din;
  logic             issue_valid;
  logic [AW-1:0]    issue_rd;
  logic             issue_ready;
  logic [AW-1:0]    rs1, rs2;
  logic             rs1_busy, rs2_busy, idle;

  int n_cmp = 0;
  int n_err = 0;
  wb_req_t sb_q[$];
  logic [DW-1:0] model [32];

  regfile_wb_scheduler #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_data(req_data), .wr_en(wr_en), .wr_rd(wr_rd),
    .wr_din(wr_din), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_ready(issue_ready), .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy),
    .rs2_busy(rs2_busy), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] rd, input logic [DW-1:0] d);
    req_rd[i*AW +: AW]   = rd;
    req_data[i*DW +: DW] = d;
  endtask

  // Scoreboard: accepted non-x0 writes must reach the write port in order, one cycle later.
  always @(negedge clk) begin
    wb_req_t e;
    if (rst) begin
      sb_q.delete();
    end else begin
      chk("ready_onehot", $countones(req_ready) <= 1, 1);
      if (wr_en) begin
        chk("sb_avail", sb_q.size() != 0, 1);
        chk("wr_not_x0", wr_rd != '0, 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("wb_rd", wr_rd, e.rd);
          chk("wb_din", wr_din, e.data);
        end
        model[wr_rd] = wr_din;
      end
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ready[i] && req_rd[i*AW +: AW] != '0) begin
          e.rd   = req_rd[i*AW +: AW];
          e.data = req_data[i*DW +: DW];
          sb_q.push_back(e);
        end
      end
    end
  end

  initial begin
    logic [NR-1:0] exp_g [4];
    logic [AW-1:0] exp_rd [4];
    logic [NR-1:0] taken;
    int wcnt [NR];

    for (int r = 0; r < 32; r++) model[r] = '0;
    rst = 1'b1; req_valid = '0; req_rd = '0; req_data = '0;
    issue_valid = 1'b0; issue_rd = '0; rs1 = '0; rs2 = '0;
    tick();
    tick();
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_rd", wr_rd, 0);
    chk("rst_wr_din", wr_din, 0);
    chk("rst_idle", idle, 1);
    chk("rst_req_ready", req_ready, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_idle", idle, 1);
    chk("post_rst_ready", req_ready, 0);

    // round-robin with all three requesters held valid
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
    exp_rd[0] = 5;     exp_rd[1] = 6;     exp_rd[2] = 7;     exp_rd[3] = 5;
    for (int i = 0; i < NR; i++) set_req(i, AW'(5 + i), 32'hA000_0000 + DW'(i));
    req_valid = 3'b111;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr_grant%0d", k), req_ready, exp_g[k]);
      if (k > 0) begin
        chk($sformatf("rr_wr_rd%0d", k), wr_rd, exp_rd[k-1]);
        chk($sformatf("rr_wr_en%0d", k), wr_en, 1);
      end
      tick();
    end
    req_valid = '0;
    chk("rr_wr_rd_last", wr_rd, 5);
    chk("rr_wr_en_last", wr_en, 1);
    tick();
    chk("rr_wr_en_off", wr_en, 0);
    chk("rr_idle", idle, 1);

    // reserve x9, back-to-back WAW stalls, write commits and clears busy
    issue_valid = 1'b1; issue_rd = 9; rs1 = 9;
    #1;
    chk("x9_issue_ok", issue_ready, 1);
    chk("x9_not_busy", rs1_busy, 0);
    tick();
    chk("x9_waw_stall", issue_ready, 0);
    chk("x9_busy", rs1_busy, 1);
    chk("x9_not_idle", idle, 0);
    set_req(1, 9, 32'hDEAD_BEEF);
    req_valid = 3'b010;
    #1;
    chk("x9_grant1", req_ready, 3'b010);
    tick();
    req_valid = '0;
    chk("x9_wr_en", wr_en, 1);
    chk("x9_busy_wr_cycle", rs1_busy, 1);
    chk("x9_stall_wr_cycle", issue_ready, 0);
    tick();
    chk("x9_busy_cleared", rs1_busy, 0);
    chk("x9_issue_reopen", issue_ready, 1);
    chk("x9_regfile", model[9], 32'hDEAD_BEEF);
    tick();
    issue_valid = 1'b0;
    chk("x9_rereserved", rs1_busy, 1);
    set_req(2, 9, 32'h1234_5678);
    req_valid = 3'b100;
    tick();
    req_valid = '0;
    tick();
    chk("x9_clear2", rs1_busy, 0);
    chk("x9_regfile2", model[9], 32'h1234_5678);

    // commit of x4 and a fresh reservation of x4 on the same edge
    set_req(0, 4, 32'h44);
    req_valid = 3'b001;
    #1;
    chk("x4_grant0", req_ready, 3'b001);
    tick();
    req_valid = '0;
    issue_valid = 1'b1; issue_rd = 4; rs1 = 4;
    #1;
    chk("x4_wr_en", wr_en, 1);
    chk("x4_issue_ok", issue_ready, 1);
    tick();
    issue_valid = 1'b0;
    chk("x4_set_wins", rs1_busy, 1);
    chk("x4_not_idle", idle, 0);
    set_req(1, 4, 32'h45);
    req_valid = 3'b010;
    #1;
    chk("x4_grant1", req_ready, 3'b010);
    tick();
    req_valid = '0;
    tick();
    chk("x4_cleared", rs1_busy, 0);
    chk("x4_idle", idle, 1);

    // x0: never reserved, writes accepted but dropped
    rs1 = 0; issue_valid = 1'b1; issue_rd = 0;
    #1;
    chk("x0_issue_ok", issue_ready, 1);
    tick();
    issue_valid = 1'b0;
    chk("x0_never_busy", rs1_busy, 0);
    chk("x0_idle", idle, 1);
    set_req(2, 0, 32'h1);
    req_valid = 3'b100;
    #1;
    chk("x0_grant", req_ready, 3'b100);
    tick();
    req_valid = '0;
    chk("x0_wr_en", wr_en, 0);
    chk("x0_idle2", idle, 1);

    // asynchronous reset while a write is in flight and x12 reserved
    issue_valid = 1'b1; issue_rd = 12; rs2 = 12;
    tick();
    issue_valid = 1'b0;
    chk("x12_busy", rs2_busy, 1);
    set_req(0, 3, 32'h33);
    req_valid = 3'b001;
    tick();
    req_valid = '0;
    chk("mid_wr_en", wr_en, 1);
    rst = 1'b1;
    #1;
    chk("arst_wr_en", wr_en, 0);
    chk("arst_busy", rs2_busy, 0);
    chk("arst_idle", idle, 1);
    tick();
    rst = 1'b0;
    tick();
    chk("arst_after_idle", idle, 1);

    // random writeback traffic, requesters hold until granted
    for (int i = 0; i < NR; i++) wcnt[i] = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          set_req(i, AW'($urandom_range(0, 7)), DW'($urandom));
          req_valid[i] = 1'b1;
        end
      end
      #1;
      taken = req_valid & req_ready;
      if (req_valid != '0) chk("rnd_some_grant", taken != '0, 1);
      for (int i = 0; i < NR; i++) begin
        if (taken[i]) begin
          chk("rr_wait", wcnt[i] <= NR - 1, 1);
          wcnt[i] = 0;
        end else if (req_valid[i]) begin
          wcnt[i]++;
        end
      end
      tick();
      req_valid = req_valid & ~taken;
    end
    req_valid = '0;
    tick();
    tick();
    chk("final_idle", idle, 1);
    chk("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
